// File: rtl/acl_tx_scheduler.sv
// acl_tx_scheduler
// Master-side per-slot ACL transmit scheduler. On every master TX slot
// opportunity it picks the LT_ADDR (1..7) to address and the packet type,
// in priority order: ARQ retransmissions, expired poll timers, fresh data.
// Each class is searched round-robin from a shared pointer. Multi-slot packets
// hold the scheduler off for the slots they occupy.
//
// Optional feature macro: SCHED_POLL_EN
//   defined   : per-link poll counters and the poll-expired class exist
//   undefined : only retransmission and data classes, POLL never generated
//
// Ports:
//   clk_6M, rstz          clock, async active-low reset
//   regi_isMaster         device is piconet master
//   regi_sched_en         scheduler enable
//   regi_active_lt[7:1]   connected LT_ADDRs
//   regi_txdatready[7:1]  ACL payload queued per LT_ADDR
//   regi_packet_type      packet type for data packets
//   regi_tpoll            poll interval in TX opportunities
//   srcFLOW[7:1]          remote link accepts data (GO)
//   retx_pend[7:1]        last data packet NAKed, must be resent
//   ms_tslot_p            pulse at start of each master TX slot
//   connsnew              new-connection pulse, soft reset
//   sched_valid_p         one-clk pulse, decision valid
//   sched_lt_addr         addressed LT_ADDR (held)
//   sched_pktype          packet type (held)
//   sched_retx            decision is a retransmission (held)
//   sched_busy            multi-slot holdoff in progress
module acl_tx_scheduler #(
  parameter int unsigned TPOLL_W = 8
) (
  input  logic               clk_6M,
  input  logic               rstz,
  input  logic               regi_isMaster,
  input  logic               regi_sched_en,
  input  logic [7:0]         regi_active_lt,
  input  logic [7:0]         regi_txdatready,
  input  logic [3:0]         regi_packet_type,
  input  logic [TPOLL_W-1:0] regi_tpoll,
  input  logic [7:0]         srcFLOW,
  input  logic [7:0]         retx_pend,
  input  logic               ms_tslot_p,
  input  logic               connsnew,
  output logic               sched_valid_p,
  output logic [2:0]         sched_lt_addr,
  output logic [3:0]         sched_pktype,
  output logic               sched_retx,
  output logic               sched_busy
);

  typedef enum logic [1:0] {IDLE, READY, ISSUE, HOLD} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [1:0] hold_q, hold_d;
  logic       valid_d;
  logic [2:0] lt_d;
  logic [3:0] pktype_d;
  logic       retx_d;
  logic       busy_d;

  logic       run;
  logic [7:1] act;
  logic [7:1] c1_mask;
  logic [7:1] c3_mask;
  logic [3:0] pick1;
  logic [3:0] pick3;
  logic       win_found;
  logic [2:0] win_lt;
  logic [3:0] win_pk;
  logic       win_retx;
  logic       grant;

  // Round-robin search from ptr upward, wrapping 7->1; returns {found, idx}.
  function automatic logic [3:0] rr_pick(input logic [7:1] mask, input logic [2:0] ptr);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    idx = ptr;
    for (int k = 0; k < 7; k++) begin
      if (!res[3] && mask[idx]) res = {1'b1, idx};
      idx = (idx == 3'd7) ? 3'd1 : idx + 3'd1;
    end
    return res;
  endfunction

  // Slot opportunities to skip after a grant: (N-1)/2 for an N-slot packet.
  function automatic logic [1:0] holdoff_of(input logic [3:0] pk);
    logic [1:0] h;
    case (pk)
      4'ha, 4'hb: h = 2'd1;
      4'he, 4'hf: h = 2'd2;
      default:    h = 2'd0;
    endcase
    return h;
  endfunction

  assign run     = regi_isMaster & regi_sched_en & ~connsnew;
  assign act     = regi_active_lt[7:1];
  assign c1_mask = act & retx_pend[7:1] & srcFLOW[7:1];
  assign c3_mask = act & regi_txdatready[7:1] & srcFLOW[7:1];
  assign pick1   = rr_pick(c1_mask, ptr_q);
  assign pick3   = rr_pick(c3_mask, ptr_q);

`ifdef SCHED_POLL_EN
  localparam logic [3:0] PKT_POLL = 4'h1;

  logic [7:1][TPOLL_W-1:0] cnt_q, cnt_d;
  logic [7:1]              c2_mask;
  logic [3:0]              pick2;
  logic                    tick;

  // Expired-poll candidates.
  always_comb begin
    c2_mask = '0;
    for (int n = 1; n <= 7; n++) begin
      c2_mask[3'(n)] = act[3'(n)] && (cnt_q[3'(n)] == '0);
    end
  end

  assign pick2 = rr_pick(c2_mask, ptr_q);
  assign tick  = run && ms_tslot_p && (state_q == READY || state_q == HOLD);
`endif

  // Class priority: retransmission, then poll-expired, then data.
  always_comb begin
    win_found = 1'b0;
    win_lt    = ptr_q;
    win_pk    = regi_packet_type;
    win_retx  = 1'b0;
    if (pick1[3]) begin
      win_found = 1'b1;
      win_lt    = pick1[2:0];
      win_retx  = 1'b1;
    end
`ifdef SCHED_POLL_EN
    else if (pick2[3]) begin
      win_found = 1'b1;
      win_lt    = pick2[2:0];
      win_pk    = c3_mask[pick2[2:0]] ? regi_packet_type : PKT_POLL;
    end
`endif
    else if (pick3[3]) begin
      win_found = 1'b1;
      win_lt    = pick3[2:0];
    end
  end

  assign grant = run && (state_q == READY) && ms_tslot_p && win_found;

  // FSM next-state and registered-output next values.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    valid_d  = 1'b0;
    lt_d     = sched_lt_addr;
    pktype_d = sched_pktype;
    retx_d   = sched_retx;
    if (!run) begin
      state_d = IDLE;
      ptr_d   = 3'd1;
      hold_d  = 2'd0;
    end else begin
      case (state_q)
        IDLE:  state_d = READY;
        READY: begin
          if (ms_tslot_p) begin
            state_d = ISSUE;
            hold_d  = 2'd0;
            if (win_found) begin
              valid_d  = 1'b1;
              lt_d     = win_lt;
              pktype_d = win_pk;
              retx_d   = win_retx;
              ptr_d    = (win_lt == 3'd7) ? 3'd1 : win_lt + 3'd1;
              // Holdoff is latched here, so later packet type changes don't affect it.
              hold_d   = holdoff_of(win_pk);
            end
          end
        end
        ISSUE: state_d = (hold_q != 2'd0) ? HOLD : READY;
        HOLD: begin
          if (ms_tslot_p) begin
            hold_d = hold_q - 2'd1;
            // The pulse that drains the holdoff is consumed, not arbitrated.
            if (hold_q <= 2'd1) state_d = READY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == HOLD);
  end

`ifdef SCHED_POLL_EN
  // Poll counters: reload in IDLE and for inactive links, saturating decrement
  // per slot, and a grant reload overrides the decrement of the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    for (int n = 1; n <= 7; n++) begin
      if (!run || state_q == IDLE || !act[3'(n)]) begin
        cnt_d[3'(n)] = regi_tpoll;
      end else if (tick && cnt_q[3'(n)] != '0) begin
        cnt_d[3'(n)] = cnt_q[3'(n)] - TPOLL_W'(1);
      end
    end
    if (grant) cnt_d[win_lt] = regi_tpoll;
  end

  // Counters reset to zero; the IDLE state that follows reset loads regi_tpoll
  // before any arbitration can observe them.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  // State and output registers.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q       <= IDLE;
      ptr_q         <= 3'd1;
      hold_q        <= 2'd0;
      sched_valid_p <= 1'b0;
      sched_lt_addr <= 3'd0;
      sched_pktype  <= 4'd0;
      sched_retx    <= 1'b0;
      sched_busy    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_q        <= hold_d;
      sched_valid_p <= valid_d;
      sched_lt_addr <= lt_d;
      sched_pktype  <= pktype_d;
      sched_retx    <= retx_d;
      sched_busy    <= busy_d;
    end
  end

  // LT_ADDR 0 is never scheduled, so bit 0 of the per-link vectors is unused.
  logic unused_bits;
`ifdef SCHED_POLL_EN
  assign unused_bits = ^{regi_active_lt[0], regi_txdatready[0], srcFLOW[0], retx_pend[0]};
`else
  assign unused_bits = ^{regi_active_lt[0], regi_txdatready[0], srcFLOW[0], retx_pend[0],
                         regi_tpoll, grant};
`endif

endmodule

// File: tb/tb_acl_tx_scheduler.sv
// Testbench for acl_tx_scheduler: scoreboard of expected decisions pushed per
// slot pulse and popped when sched_valid_p is observed.
module tb_acl_tx_scheduler;

  localparam int unsigned TPOLL_W = 8;
`ifdef SCHED_POLL_EN
  localparam bit POLL_ON = 1'b1;
`else
  localparam bit POLL_ON = 1'b0;
`endif

  logic               clk_6M = 1'b0;
  logic               rstz;
  logic               regi_isMaster;
  logic               regi_sched_en;
  logic [7:0]         regi_active_lt;
  logic [7:0]         regi_txdatready;
  logic [3:0]         regi_packet_type;
  logic [TPOLL_W-1:0] regi_tpoll;
  logic [7:0]         srcFLOW;
  logic [7:0]         retx_pend;
  logic               ms_tslot_p;
  logic               connsnew;
  logic               sched_valid_p;
  logic [2:0]         sched_lt_addr;
  logic [3:0]         sched_pktype;
  logic               sched_retx;
  logic               sched_busy;

  typedef struct packed {
    logic [2:0] lt;
    logic [3:0] pk;
    logic       retx;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  acl_tx_scheduler #(.TPOLL_W(TPOLL_W)) dut (
    .clk_6M           (clk_6M),
    .rstz             (rstz),
    .regi_isMaster    (regi_isMaster),
    .regi_sched_en    (regi_sched_en),
    .regi_active_lt   (regi_active_lt),
    .regi_txdatready  (regi_txdatready),
    .regi_packet_type (regi_packet_type),
    .regi_tpoll       (regi_tpoll),
    .srcFLOW          (srcFLOW),
    .retx_pend        (retx_pend),
    .ms_tslot_p       (ms_tslot_p),
    .connsnew         (connsnew),
    .sched_valid_p    (sched_valid_p),
    .sched_lt_addr    (sched_lt_addr),
    .sched_pktype     (sched_pktype),
    .sched_retx       (sched_retx),
    .sched_busy       (sched_busy)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Pop an expected decision for every observed pulse.
  always @(negedge clk_6M) begin
    if (rstz === 1'b1 && sched_valid_p === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(sched_valid_p), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("lt_addr", 32'(sched_lt_addr), 32'(e.lt));
        chk("pktype",  32'(sched_pktype),  32'(e.pk));
        chk("retx",    32'(sched_retx),    32'(e.retx));
      end
    end
  end

  // One slot pulse; the decision must appear exactly one clk later.
  task automatic slot(input bit ev, input logic [2:0] lt, input logic [3:0] pk, input logic rt);
    exp_t e;
    if (ev) begin
      e.lt = lt; e.pk = pk; e.retx = rt;
      exp_q.push_back(e);
    end
    ms_tslot_p = 1'b1;
    @(posedge clk_6M); #1 ms_tslot_p = 1'b0;
    @(negedge clk_6M); #1;
    chk("decision_latency", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) @(posedge clk_6M);
    #1;
  endtask

  task automatic soft_reset();
    connsnew = 1'b1;
    @(posedge clk_6M); #1 connsnew = 1'b0;
    repeat (2) @(posedge clk_6M);
    #1;
  endtask

  initial begin
    rstz             = 1'b0;
    regi_isMaster    = 1'b1;
    regi_sched_en    = 1'b1;
    regi_active_lt   = 8'h06;
    regi_txdatready  = 8'h06;
    regi_packet_type = 4'h4;
    regi_tpoll       = 8'd200;
    srcFLOW          = 8'hff;
    retx_pend        = 8'h00;
    ms_tslot_p       = 1'b0;
    connsnew         = 1'b0;
    repeat (3) @(posedge clk_6M);
    #1;
    chk("rst_valid", 32'(sched_valid_p), 32'd0);
    chk("rst_lt",    32'(sched_lt_addr), 32'd0);
    chk("rst_pk",    32'(sched_pktype),  32'd0);
    chk("rst_retx",  32'(sched_retx),    32'd0);
    chk("rst_busy",  32'(sched_busy),    32'd0);
    rstz = 1'b1;
    repeat (3) @(posedge clk_6M);
    #1;

    // Round-robin data
    slot(1'b1, 3'd1, 4'h4, 1'b0);
    slot(1'b1, 3'd2, 4'h4, 1'b0);

    // Retransmission beats data; pointer back to 1 after soft reset
    soft_reset();
    retx_pend = 8'h04; regi_txdatready = 8'h02;
    slot(1'b1, 3'd2, 4'h4, 1'b1);
    retx_pend = 8'h00;
    slot(1'b1, 3'd1, 4'h4, 1'b0);

    // 5-slot holdoff; packet type change mid-HOLD must not shorten it
    regi_txdatready = 8'h06; regi_packet_type = 4'hf;
    slot(1'b1, 3'd2, 4'hf, 1'b0);
    chk("busy_5slot", 32'(sched_busy), 32'd1);
    regi_packet_type = 4'h4;
    slot(1'b0, 3'd0, 4'h0, 1'b0);
    chk("busy_mid", 32'(sched_busy), 32'd1);
    slot(1'b0, 3'd0, 4'h0, 1'b0);
    chk("busy_end", 32'(sched_busy), 32'd0);
    slot(1'b1, 3'd1, 4'h4, 1'b0);

    // 3-slot holdoff
    regi_packet_type = 4'ha;
    slot(1'b1, 3'd2, 4'ha, 1'b0);
    slot(1'b0, 3'd0, 4'h0, 1'b0);
    slot(1'b1, 3'd1, 4'ha, 1'b0);
    slot(1'b0, 3'd0, 4'h0, 1'b0);

    // connsnew during HOLD clears busy and resets pointer
    regi_packet_type = 4'hf; regi_txdatready = 8'h02;
    slot(1'b1, 3'd1, 4'hf, 1'b0);
    chk("busy_pre_conn", 32'(sched_busy), 32'd1);
    connsnew = 1'b1;
    @(posedge clk_6M); #1;
    chk("busy_conn", 32'(sched_busy), 32'd0);
    connsnew = 1'b0;
    repeat (2) @(posedge clk_6M);
    #1;
    regi_packet_type = 4'h4; regi_txdatready = 8'h06;
    slot(1'b1, 3'd1, 4'h4, 1'b0);

    // Poll timer on idle link 3; later data ready but flow stopped still polls
    regi_tpoll = 8'd3; regi_active_lt = 8'h08; regi_txdatready = 8'h00; srcFLOW = 8'hff;
    soft_reset();
    for (int i = 0; i < 12; i++) begin
      if (i == 8) begin
        srcFLOW = 8'hf7; regi_txdatready = 8'h08;
      end
      slot(POLL_ON && (i % 4 == 3), 3'd3, 4'h1, 1'b0);
    end

    // Flow stopped with retx pending: silent until the poll timer expires
    regi_tpoll = 8'd10; regi_active_lt = 8'h80; srcFLOW = 8'h00;
    regi_txdatready = 8'h80; retx_pend = 8'h80;
    soft_reset();
    for (int i = 0; i < 11; i++) begin
      slot(POLL_ON && (i == 10), 3'd7, 4'h1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/acl_tx_scheduler.md
Name: acl_tx_scheduler

Overview:
- Master-side per-slot ACL transmit scheduler: at each master TX slot opportunity, picks which LT_ADDR (1..7) is addressed and with which packet type.
- Arbitration order: ARQ retransmissions, then expired poll timers, then fresh data, round-robin within each class.
- Feeds the baseband packet encoder. Consumes srcFLOW and per-link retransmit-pending status from the ARQ/flow-control block.
- Holds off for multi-slot packets.

Parameters:
TPOLL_W, 8, width of per-link poll interval counter (in TX opportunities)

Ports:
clk_6M  in  1  system clock, 6 MHz
rstz  in  1  asynchronous active-low reset
regi_isMaster  in  1  device is piconet master; scheduler idle when 0
regi_sched_en  in  1  scheduler enable
regi_active_lt  in  8  bit n=1: LT_ADDR n connected (bit 0 ignored)
regi_txdatready  in  8  bit n=1: ACL payload queued for LT_ADDR n
regi_packet_type  in  4  packet type used for new data packets
regi_tpoll  in  TPOLL_W  poll interval in TX opportunities
srcFLOW  in  8  bit n=1: remote link n accepts data (GO)
retx_pend  in  8  bit n=1: last data packet to n NAKed, must be resent
ms_tslot_p  in  1  one-clk pulse at start of every master TX slot
connsnew  in  1  new-connection pulse; soft-resets scheduler
sched_valid_p  out  1  one-clk pulse: new schedule decision valid
sched_lt_addr  out  3  addressed LT_ADDR (held until next decision)
sched_pktype  out  4  packet type to send (held)
sched_retx  out  1  decision is a retransmission (held)
sched_busy  out  1  multi-slot holdoff in progress

Behaviour:
- Reset values: sched_valid_p=0, sched_lt_addr=0, sched_pktype=0, sched_retx=0, sched_busy=0. RR pointer=1. FSM=IDLE. All poll counters=regi_tpoll.
- FSM states: IDLE, READY, ISSUE, HOLD.
  - IDLE→READY when regi_isMaster & regi_sched_en.
  - Any state→IDLE on connsnew, or when regi_isMaster or regi_sched_en is 0. Entering IDLE reloads counters and pointer, clears sched_busy, suppresses sched_valid_p. Outputs lt/pktype/retx hold their last value.
- READY, on ms_tslot_p: arbitrate over candidates n in 1..7 with regi_active_lt[n]=1, using values sampled that cycle. Go to ISSUE.
- ISSUE lasts exactly one clk:
  - sched_valid_p=1 and outputs updated only if a winner exists. Latency is 1 clk after ms_tslot_p.
  - No winner: no pulse, outputs unchanged.
  - Then → HOLD if holdoff>0, else → READY.
- Classes, highest priority first. Within a class the winner is the first n found searching from the RR pointer upward, wrapping 7→1.
  - C1 retransmission: retx_pend[n] & srcFLOW[n]. pktype=regi_packet_type, sched_retx=1.
  - C2 poll expired: counter[n]==0. pktype=regi_packet_type if regi_txdatready[n]&srcFLOW[n], else POLL (4'h1). sched_retx=0.
  - C3 data: regi_txdatready[n] & srcFLOW[n]. pktype=regi_packet_type, sched_retx=0.
- After a grant to n: pointer=n+1 (7 wraps to 1), and counter[n] reloads to regi_tpoll.
- Slot length N from pktype:
  - 4'ha/4'hb → 3.
  - 4'he/4'hf → 5.
  - Otherwise 1, including POLL and C1 when regi_packet_type is single-slot.
- holdoff = (N-1)/2, giving 0, 1 or 2 ms_tslot_p pulses to skip.
- HOLD: sched_busy=1. Each ms_tslot_p decrements holdoff; the pulse that reaches 0 returns to READY and is not used for arbitration.
- Poll counters: each ms_tslot_p in READY/HOLD decrements counter[n] of every active n, saturating at 0. Inactive n are held at regi_tpoll. regi_tpoll=0 means every active link is always expired, giving pure round-robin polling.
- A grant and a decrement for the same n in the same cycle: the reload wins.
- retx_pend[n] with srcFLOW[n]=0 is not eligible in C1. The link can still win C2 and receive a POLL.
- Changing regi_packet_type mid-HOLD does not alter the current holdoff.

Optional Feature:
SCHED_POLL_EN:
- Defined: poll counters and class C2 exist as above.
- Undefined: no counters and no C2. Only C1/C3 are arbitrated, and POLL is never generated. regi_tpoll is ignored.

Test Plan:
- Reset, isMaster=1, en=1, active=8'h06, txdatready=8'h06, srcFLOW=8'hff, pktype=4'h4; pulse ms_tslot_p ×2 → sched_valid_p 1 clk after each pulse, lt_addr 1 then 2, pktype 4'h4, retx=0.
- retx_pend=8'h04, txdatready=8'h02, pointer=1 → lt_addr=2, sched_retx=1. Next pulse with retx_pend=0 → lt_addr=1.
- pktype=4'hf (5-slot) granted → sched_busy=1; next 2 pulses give no sched_valid_p; 3rd pulse issues.
- SCHED_POLL_EN, tpoll=3, active=8'h08, no data → lt_addr=3 with pktype 4'h1 on every 4th pulse; srcFLOW[3]=0 with data ready still yields POLL.
- active=8'h80, srcFLOW=8'h00, txdatready=8'h80, retx_pend=8'h80, tpoll=10 → no sched_valid_p for 10 pulses, then POLL to lt 7.
- connsnew during HOLD → sched_busy=0 next clk, pointer=1, counters reloaded; next pulse arbitrates normally.
